// File: rtl/ram_wr_arbiter.sv
// Two-client RAM write arbiter with a block-fill sequencer.
// Round-robin arbitration between two clients; a fill command takes over the write port for fill_len cycles.
module ram_wr_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_valid,
  output logic              c0_ready,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_data,
  input  logic              c1_valid,
  output logic              c1_ready,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_data,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [LEN_W-1:0]  fill_len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_d_in
);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 1 = client 1 won the last handshake
  logic [LEN_W-1:0]  fill_cnt_q, fill_cnt_d;      // fill writes still to issue after the one on the outputs
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_W-1:0] mem_d_in_q, mem_d_in_d;
  logic              fill_busy_q, fill_busy_d;
  logic              fill_done_q, fill_done_d;

  logic arb_open;
  logic gnt0;
  logic gnt1;
  logic fill_go;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ARB;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    fill_go = (state_q == ST_ARB) && fill_start && (fill_len != '0);
    state_d = state_q;
    case (state_q)
      ST_ARB:  if (fill_go) state_d = ST_FILL;
      ST_FILL: if (fill_cnt_q == '0) state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Under contention the client that did not win the previous handshake is granted.
  always_comb begin
    arb_open      = (state_q == ST_ARB) && !fill_start;
    gnt0          = arb_open && c0_valid && (!c1_valid || last_grant_q);
    gnt1          = arb_open && c1_valid && (!c0_valid || !last_grant_q);
    c0_ready      = gnt0;
    c1_ready      = gnt1;

    last_grant_d  = last_grant_q;
    fill_cnt_d    = fill_cnt_q;
    fill_addr_d   = fill_addr_q;
    fill_data_d   = fill_data_q;
    mem_wr_d      = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_d_in_d    = mem_d_in_q;
    fill_busy_d   = 1'b0;
    fill_done_d   = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (fill_start) begin
          fill_addr_d = fill_base + ADDR_W'(1);
          fill_data_d = fill_data;
          if (fill_len == '0) begin
            fill_done_d = 1'b1;
          end else begin
            mem_wr_d      = 1'b1;
            mem_wr_addr_d = fill_base;
            mem_d_in_d    = fill_data;
            fill_busy_d   = 1'b1;
            fill_cnt_d    = fill_len - LEN_W'(1);
            fill_done_d   = (fill_len == LEN_W'(1));
          end
        end else if (gnt0) begin
          mem_wr_d      = 1'b1;
          mem_wr_addr_d = c0_addr;
          mem_d_in_d    = c0_data;
          last_grant_d  = 1'b0;
        end else if (gnt1) begin
          mem_wr_d      = 1'b1;
          mem_wr_addr_d = c1_addr;
          mem_d_in_d    = c1_data;
          last_grant_d  = 1'b1;
        end
      end
      ST_FILL: begin
        if (fill_cnt_q != '0) begin
          mem_wr_d      = 1'b1;
          mem_wr_addr_d = fill_addr_q;
          mem_d_in_d    = fill_data_q;
          fill_busy_d   = 1'b1;
          fill_cnt_d    = fill_cnt_q - LEN_W'(1);
          fill_addr_d   = fill_addr_q + ADDR_W'(1);
          fill_done_d   = (fill_cnt_q == LEN_W'(1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q  <= 1'b1;
      fill_cnt_q    <= '0;
      fill_addr_q   <= '0;
      fill_data_q   <= '0;
      mem_wr_q      <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_d_in_q    <= '0;
      fill_busy_q   <= 1'b0;
      fill_done_q   <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      fill_cnt_q    <= fill_cnt_d;
      fill_addr_q   <= fill_addr_d;
      fill_data_q   <= fill_data_d;
      mem_wr_q      <= mem_wr_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_d_in_q    <= mem_d_in_d;
      fill_busy_q   <= fill_busy_d;
      fill_done_q   <= fill_done_d;
    end
  end

  assign mem_wr      = mem_wr_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_d_in    = mem_d_in_q;
  assign fill_busy   = fill_busy_q;
  assign fill_done   = fill_done_q;

endmodule
